// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: FSM states and forwarding selects.
package hazard_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } hz_state_t;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

endpackage

// File: rtl/hazard_fwd.sv
// Forwarding select for one EX-stage source operand; the MEM-stage producer beats WB.
module hazard_fwd (
    input  logic [4:0] rs,
    input  logic [4:0] rd_m,
    input  logic       regwrite_m,
    input  logic [4:0] rd_w,
    input  logic       regwrite_w,
    output logic [1:0] sel
);
    import hazard_pkg::*;

    logic w_mem_hit;
    logic w_wb_hit;

    assign w_mem_hit = regwrite_m && (rd_m != 5'd0) && (rd_m == rs);
    assign w_wb_hit  = regwrite_w && (rd_w != 5'd0) && (rd_w == rs);

    always_comb begin
        sel = FWD_RF;
        if (w_mem_hit) begin
            sel = FWD_MEM;
        end else if (w_wb_hit) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: stalls, flushes, mul/div occupancy and EX forwarding.
// Optional performance counters are built when HAZARD_PERF_EN is defined.
module hazard_unit
`ifdef HAZARD_PERF_EN
#(
    parameter int XLEN = 32
)
`endif
(
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] rs1_d,
    input  logic [4:0] rs2_d,
    input  logic [4:0] rs1_e,
    input  logic [4:0] rs2_e,
    input  logic [4:0] rd_e,
    input  logic       ex_load,
    input  logic       ex_md_valid,
    input  logic       ex_branch_taken,
    input  logic [4:0] rd_m,
    input  logic [4:0] rd_w,
    input  logic       regwrite_m,
    input  logic       regwrite_w,
    input  logic       dmem_stall,
    input  logic       md_done,
    output logic       md_start,
    output logic       pc_en,
    output logic       fd_en,
    output logic       de_en,
    output logic       em_en,
    output logic       mw_en,
    output logic       fd_clr,
    output logic       de_clr,
    output logic       em_clr,
    output logic       mw_clr,
    output logic [1:0] fwd_a_e,
    output logic [1:0] fwd_b_e
`ifdef HAZARD_PERF_EN
    ,
    output logic [XLEN-1:0] stall_cycles,
    output logic [XLEN-1:0] flush_count
`endif
);
    import hazard_pkg::*;

    hz_state_t r_state;
    hz_state_t w_state_next;
    logic      r_md_done_q;
    logic      w_md_done_q_next;
    logic      w_load_use;
    logic      w_md_finished;

    hazard_fwd u_fwd_a (
        .rs         (rs1_e),
        .rd_m       (rd_m),
        .regwrite_m (regwrite_m),
        .rd_w       (rd_w),
        .regwrite_w (regwrite_w),
        .sel        (fwd_a_e)
    );

    hazard_fwd u_fwd_b (
        .rs         (rs2_e),
        .rd_m       (rd_m),
        .regwrite_m (regwrite_m),
        .rd_w       (rd_w),
        .regwrite_w (regwrite_w),
        .sel        (fwd_b_e)
    );

    assign w_load_use    = ex_load && (rd_e != 5'd0) && ((rd_e == rs1_d) || (rd_e == rs2_d));
    assign w_md_finished = md_done || r_md_done_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= RUN;
            r_md_done_q <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_md_done_q <= w_md_done_q_next;
        end
    end

    // Strict priority chain: only the highest active hazard drives the pipeline controls.
    always_comb begin
        w_state_next     = r_state;
        w_md_done_q_next = r_md_done_q;
        md_start         = 1'b0;
        pc_en            = 1'b1;
        fd_en            = 1'b1;
        de_en            = 1'b1;
        em_en            = 1'b1;
        mw_en            = 1'b1;
        fd_clr           = 1'b0;
        de_clr           = 1'b0;
        em_clr           = 1'b0;
        mw_clr           = 1'b0;

        if (dmem_stall) begin
            pc_en            = 1'b0;
            fd_en            = 1'b0;
            de_en            = 1'b0;
            em_en            = 1'b0;
            mw_clr           = 1'b1;
            w_md_done_q_next = r_md_done_q || md_done;
        end else if ((r_state == RUN) && ex_md_valid) begin
            md_start     = 1'b1;
            w_state_next = MD_WAIT;
            pc_en        = 1'b0;
            fd_en        = 1'b0;
            de_en        = 1'b0;
            em_clr       = 1'b1;
        end else if ((r_state == MD_WAIT) && !w_md_finished) begin
            pc_en  = 1'b0;
            fd_en  = 1'b0;
            de_en  = 1'b0;
            em_clr = 1'b1;
        end else if (r_state == MD_WAIT) begin
            w_state_next     = RUN;
            w_md_done_q_next = 1'b0;
        end else if (ex_branch_taken) begin
            // A taken branch also squashes any load-use dependent, which is on the wrong path.
            fd_clr = 1'b1;
            de_clr = 1'b1;
        end else if (w_load_use) begin
            pc_en  = 1'b0;
            fd_en  = 1'b0;
            de_clr = 1'b1;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [XLEN-1:0] r_stall_cycles;
    logic [XLEN-1:0] r_flush_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if (!pc_en) begin
                r_stall_cycles <= r_stall_cycles + XLEN'(1);
            end
            if (fd_clr) begin
                r_flush_count <= r_flush_count + XLEN'(1);
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_count  = r_flush_count;
`endif

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard controller for the 5-stage RV32 core. Drives the `en`/`clr` pins of the four pipeline registers (F/D, D/E, E/M, M/W) and the PC enable. Resolves load-use stalls, taken-branch flushes, data-memory wait states and multi-cycle mul/div occupancy, and generates EX-stage forwarding selects. Sits beside the datapath and has no datapath storage of its own beyond its FSM and sticky flags.

## Interface
- `XLEN`, 32: width of the optional performance counters.
- `clk` in 1: core clock.
- `rst` in 1: asynchronous, active-high reset.
- `rs1_d`, `rs2_d` in 5: source registers of the instruction in Decode.
- `rs1_e`, `rs2_e`, `rd_e` in 5: sources and destination of the instruction in Execute.
- `ex_load` in 1: the instruction in Execute is a load.
- `ex_md_valid` in 1: the instruction in Execute is a mul/div op.
- `ex_branch_taken` in 1: a branch or jump in Execute redirects the PC.
- `rd_m`, `rd_w` in 5: destinations in Memory and Writeback.
- `regwrite_m`, `regwrite_w` in 1: write enables in Memory and Writeback.
- `dmem_stall` in 1: level signal; the data memory has not completed the access in Memory.
- `md_done` in 1: one-cycle pulse; the mul/div result is valid this cycle.
- `md_start` out 1: one-cycle pulse that launches the mul/div unit.
- `pc_en`, `fd_en`, `de_en`, `em_en`, `mw_en` out 1: pipeline register enables.
- `fd_clr`, `de_clr`, `em_clr`, `mw_clr` out 1: pipeline register synchronous flushes.
- `fwd_a_e`, `fwd_b_e` out 2: operand forwarding selects. Encoding: 00 = regfile, 01 = WB, 10 = MEM.
- `stall_cycles`, `flush_count` out XLEN: present only under `HAZARD_PERF_EN`.

## Operation
- **FSM states:** `RUN` and `MD_WAIT`. Reset state is `RUN`. The `md_done_q` flag resets to 0.
- **Default outputs:** all `*_en` = 1, all `*_clr` = 0, `md_start` = 0.
- **Forwarding (combinational):**
  - A MEM match is `regwrite_m` && `rd_m` != 0 && `rd_m` == `rs*_e`. It selects 10 and beats a WB match.
  - A WB match uses the same rule with `_w` and selects 01.
  - Otherwise the select is 00.
- **Hazard priority, highest first. Only the highest active hazard applies.**
  1. **dmem_stall:** `pc_en`, `fd_en`, `de_en`, `em_en` = 0 and `mw_clr` = 1. The FSM holds its state. An `md_done` pulse arriving in this cycle sets `md_done_q`.
  2. **MD stall:**
     - In `RUN` with `ex_md_valid`: assert `md_start`, go to `MD_WAIT`, and hold PC, F/D, D/E with `em_clr` = 1.
     - In `MD_WAIT` without (`md_done` || `md_done_q`): same hold, no `md_start`.
     - In `MD_WAIT` with (`md_done` || `md_done_q`): release with default outputs, clear `md_done_q`, return to `RUN`.
  3. **Branch flush:** when `ex_branch_taken`, `fd_clr` = 1 and `de_clr` = 1. All enables stay 1.
  4. **Load-use:** when `ex_load` && `rd_e` != 0 && (`rd_e` == `rs1_d` || `rd_e` == `rs2_d`), `pc_en` = 0, `fd_en` = 0 and `de_clr` = 1.
- **Branch versus load-use in the same cycle:** the flush wins, because the dependent instruction is on the wrong path.
- **Mul/div contract:** `md_done` never arrives in the same cycle as `md_start`. `ex_md_valid` stays high while the op is held in Execute.

## Timing
- Forwarding and hazard outputs are combinational from the inputs and the current state, with zero latency.
- A load-use hazard costs exactly 1 bubble. A taken branch costs 2 flushed slots.
- A mul/div op with unit latency N cycles holds Execute for N cycles. Its result is captured into E/M on the `md_done` edge, or on the first cycle with `dmem_stall` low if `md_done_q` is set.
- Asserting `rst` mid-`MD_WAIT` returns the FSM to `RUN` and clears the flag. The mul/div unit is reset by the same `rst`.

## Configuration
- **`HAZARD_PERF_EN` defined:**
  - `stall_cycles` counts cycles with `pc_en` = 0.
  - `flush_count` counts cycles with `fd_clr` = 1.
  - Both reset to 0 and wrap modulo 2^XLEN.
- **`HAZARD_PERF_EN` undefined:** the counter ports and logic are absent.

## Structure
- `hazard_pkg` holds:
  - the `hz_state_t` enum (`RUN`, `MD_WAIT`);
  - the `fwd_sel_t` enum (`FWD_RF` = 2'b00, `FWD_WB` = 2'b01, `FWD_MEM` = 2'b10).
- Sub-module `hazard_fwd`: one 2-bit select from (`rs`, `rd_m`, `regwrite_m`, `rd_w`, `regwrite_w`). It is instantiated twice, once per operand.

## Test plan
- **Forwarding priority:** `rs1_e` = 5, `rd_m` = 5, `rd_w` = 5, both regwrites 1 -> `fwd_a_e` = 10. Repeat with `rd_m` = 0 -> `fwd_a_e` = 01.
- **Load-use stall:** `ex_load` = 1, `rd_e` = 3, `rs2_d` = 3 -> one cycle with `pc_en` = 0, `fd_en` = 0, `de_clr` = 1. Then default outputs.
- **Flush beats stall:** `ex_branch_taken` with a simultaneous load-use -> `fd_clr` = `de_clr` = 1 and `pc_en` = 1.
- **Mul/div wait:** `ex_md_valid` held with `md_done` 4 cycles later -> `md_start` pulses once. The hold lasts 4 cycles with `em_clr` = 1. Release happens on the `md_done` cycle and the FSM returns to `RUN`.
- **dmem_stall over md_done:** `md_done` pulses while `dmem_stall` = 1 -> all front enables stay 0 and `md_done_q` sets. Release happens on the first cycle `dmem_stall` falls.
- **Perf counters:** with `HAZARD_PERF_EN`, 3 stall cycles and 1 flush -> `stall_cycles` = 3 and `flush_count` = 1. Asserting `rst` mid-wait -> both counters 0 and state `RUN`.
